axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE: Single-beat AXI responder backed by a word-addressed on-chip RAM; the target for the CPU's SRAM-to-AXI
//   bridge in simulation and FPGA bring-up. Independent read and write channels; AR/AW/W handshakes, R/B responses
//   carrying the echoed ID. Bursts unsupported: every transfer is one 32-bit beat.
// PARAMETERS:
//   AW_WORDS  16  log2 of RAM depth in 32-bit words (word index = addr[AW_WORDS+1:2])
//   RD_LAT    1   cycles from AR handshake to rvalid assertion, 1..15
//   WR_LAT    1   cycles from last of AW/W handshake to bvalid assertion, 1..15
// PORTS:
//   aclk     in   1   clock, rising edge
//   aresetn  in   1   asynchronous active-low reset
//   arid     in   4   read ID, latched on AR handshake
//   araddr   in   32  read byte address
//   arvalid  in   1   read request valid
//   arready  out  1   read request accepted
//   rid      out  4   latched arid
//   rdata    out  32  read word
//   rresp    out  2   2'b00 OKAY, 2'b10 SLVERR
//   rvalid   out  1   read data valid
//   rready   in   1   master accepts read data
//   awid     in   4   write ID, latched on AW handshake
//   awaddr   in   32  write byte address
//   awvalid  in   1   write address valid
//   awready  out  1   write address accepted
//   wdata    in   32  write word
//   wstrb    in   4   byte enables, bit i -> wdata[8i+7:8i]
//   wvalid   in   1   write data valid
//   wready   out  1   write data accepted
//   bid      out  4   latched awid
//   bresp    out  2   2'b00 OKAY, 2'b10 SLVERR
//   bvalid   out  1   write response valid
//   bready   in   1   master accepts write response
// BEHAVIOUR:
// - Reset (async, aresetn=0): read FSM R_IDLE, write FSM W_IDLE, counters 0; arready=awready=wready=1 (0 if
//   RAND_DELAY_EN), rvalid=bvalid=0, rid=bid=0, rdata=0, rresp=bresp=0. RAM contents not reset.
// - Read FSM: R_IDLE (arready=1) -AR hs-> R_WAIT (arready=0, count RD_LAT-1) -count 0-> R_RESP (rvalid=1,
//   outputs stable) -R hs-> R_IDLE. RD_LAT=1: R_WAIT skipped, rvalid one cycle after AR hs. Max one read in flight.
// - RAM read sampled on entering R_RESP; held in rdata until R handshake.
// - Write FSM: W_IDLE (awready=wready=1); AW hs alone -> W_GOTA (awready=0, wait W); W hs alone -> W_GOTW
//   (wready=0, wait AW); both same cycle or second arrives -> W_WAIT (count WR_LAT-1) -> W_RESP (bvalid=1) -B hs->
//   W_IDLE. RAM written with wstrb mask on the cycle entering W_RESP. Max one write in flight.
// - Word index >= 2**AW_WORDS never occurs by construction; address bits above AW_WORDS+1 nonzero -> SLVERR:
//   write dropped, rdata=0. addr[1:0] ignored (full word returned; master extracts bytes).
// - Read sample and write commit to same word in same cycle: write-first, read returns new merged data.
// - rvalid/bvalid stay high until handshake regardless of rready/bready; no combinational in->out paths.
// - Reset mid-transaction: in-flight request discarded, no response issued after reset release.
// CONFIGURATION:
// - AXI_SLAVE_RAND_DELAY_EN defined: 8-bit LFSR (seed 8'hA5, x^8+x^6+x^5+x^4+1) adds 0..3 stall cycles before each
//   arready/awready/wready assertion and before rvalid/bvalid; ready low in idle until stall expires.
// - Undefined: fixed timing exactly as above (ready high in idle, RD_LAT/WR_LAT exact).
// TESTING:
// - Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, AW and W same cycle, id=1 -> bvalid after WR_LAT, bid=1, bresp=0.
// - Read araddr=0x10 id=0, rready=1 -> rvalid exactly RD_LAT cycles after AR hs, rdata=0xDEADBEEF, rid=0, rresp=0.
// - W precedes AW by 3 cycles, wstrb=4'b0010, wdata=0x0000AB00 -> subsequent read returns 0xDEADABEF.
// - Hold rready=0 for 5 cycles -> rvalid, rdata, rid stable; arready=0 throughout; next AR accepted after R hs.
// - araddr with bit 31 set -> rresp=2'b10, rdata=0; awaddr bit 31 set -> bresp=2'b10, RAM unchanged.
// - Assert aresetn=0 in R_WAIT -> rvalid=0 immediately, arready=1 after release, no stray R beat.

Source files
------------

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// Purpose:
//   Single-beat AXI responder in front of a word-addressed on-chip RAM. Used as
//   the target of the CPU's SRAM-to-AXI bridge in simulation and on the FPGA
//   during bring-up. Read and write channels are independent, and each channel
//   has at most one transfer in flight. Every transfer is a single 32-bit beat.
//   Bursts are not supported.
//
// Parameters:
//   AW_WORDS  log2 of the RAM depth in 32-bit words (word index = addr[AW_WORDS+1:2])
//   RD_LAT    cycles from the AR handshake to rvalid, 1..15
//   WR_LAT    cycles from the later of the AW/W handshakes to bvalid, 1..15
//
// Ports:
//   i_aclk, i_aresetn          clock (rising edge), asynchronous active-low reset
//   i_arid/i_araddr/i_arvalid  read request; o_arready accepts it
//   o_rid/o_rdata/o_rresp      read response, held while o_rvalid is set until i_rready
//   i_awid/i_awaddr/i_awvalid  write address; o_awready accepts it
//   i_wdata/i_wstrb/i_wvalid   write data with byte enables; o_wready accepts it
//   o_bid/o_bresp              write response, held while o_bvalid is set until i_bready
//   Response codes: 2'b00 OKAY, 2'b10 SLVERR (address bits above the RAM are nonzero)
//
// Configuration macro:
//   AXI_SLAVE_RAND_DELAY_EN  When defined, an 8-bit LFSR (seed 8'hA5,
//                            x^8+x^6+x^5+x^4+1) inserts 0..3 stall cycles before
//                            each ready assertion and before each response.
//                            When undefined, the timing is fixed: ready is high
//                            while idle, and the latencies are exactly RD_LAT and
//                            WR_LAT.
// -----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int AW_WORDS = 16,
  parameter int RD_LAT   = 1,
  parameter int WR_LAT   = 1
) (
  input  logic        i_aclk,
  input  logic        i_aresetn,
  input  logic [3:0]  i_arid,
  input  logic [31:0] i_araddr,
  input  logic        i_arvalid,
  output logic        o_arready,
  output logic [3:0]  o_rid,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rvalid,
  input  logic        i_rready,
  input  logic [3:0]  i_awid,
  input  logic [31:0] i_awaddr,
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_wvalid,
  output logic        o_wready,
  output logic [3:0]  o_bid,
  output logic [1:0]  o_bresp,
  output logic        o_bvalid,
  input  logic        i_bready
);

  localparam int         DEPTH       = 1 << AW_WORDS;
  localparam logic [4:0] RD_BASE     = 5'(RD_LAT - 1);
  localparam logic [4:0] WR_BASE     = 5'(WR_LAT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [2:0] {W_IDLE, W_GOTA, W_GOTW, W_WAIT, W_RESP} wr_state_t;

  logic [31:0] r_mem [DEPTH];

  rd_state_t   r_rd_state, w_rd_state_next;
  wr_state_t   r_wr_state, w_wr_state_next;
  logic [4:0]  r_rd_cnt, w_rd_cnt_next;
  logic [4:0]  r_wr_cnt, w_wr_cnt_next;

  logic [31:0] r_ar_addr, r_aw_addr, r_wdata;
  logic [3:0]  r_rid, r_bid, r_wstrb;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp, r_bresp;

  logic        w_ar_hs, w_aw_hs, w_w_hs, w_wr_go;
  logic        w_rd_sample, w_wr_commit, w_mem_we;
  logic [31:0] w_rd_addr, w_wr_addr, w_wr_data, w_rd_mem, w_rd_merged;
  logic [3:0]  w_wr_strb;
  logic [AW_WORDS-1:0] w_rd_idx, w_wr_idx;
  logic        w_rd_err, w_wr_err;
  logic [4:0]  w_rd_total, w_wr_total;
  logic [1:0]  w_rd_extra, w_wr_extra;
  logic        w_ar_stall_done, w_wr_stall_done;
  logic        w_unused;

  // ---------------------------------------------------------------------------
  // Optional random stalls
  // ---------------------------------------------------------------------------
`ifdef AXI_SLAVE_RAND_DELAY_EN
  logic [7:0] r_lfsr;
  logic [1:0] r_ar_stall, r_wr_stall;

  // The stall counters come out of reset nonzero, so ready is low straight
  // after reset and rises only once the first stall has expired.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_lfsr     <= 8'hA5;
      r_ar_stall <= 2'd1;
      r_wr_stall <= 2'd1;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      if (r_rd_state != R_IDLE && w_rd_state_next == R_IDLE)
        r_ar_stall <= r_lfsr[1:0];
      else if (r_rd_state == R_IDLE && r_ar_stall != 2'd0)
        r_ar_stall <= r_ar_stall - 2'd1;
      if (r_wr_state != W_IDLE && w_wr_state_next == W_IDLE)
        r_wr_stall <= r_lfsr[5:4];
      else if (r_wr_state == W_IDLE && r_wr_stall != 2'd0)
        r_wr_stall <= r_wr_stall - 2'd1;
    end
  end

  assign w_ar_stall_done = (r_ar_stall == 2'd0);
  assign w_wr_stall_done = (r_wr_stall == 2'd0);
  assign w_rd_extra      = r_lfsr[3:2];
  assign w_wr_extra      = r_lfsr[7:6];
`else
  assign w_ar_stall_done = 1'b1;
  assign w_wr_stall_done = 1'b1;
  assign w_rd_extra      = 2'd0;
  assign w_wr_extra      = 2'd0;
`endif

  assign w_rd_total = RD_BASE + {3'd0, w_rd_extra};
  assign w_wr_total = WR_BASE + {3'd0, w_wr_extra};

  // ---------------------------------------------------------------------------
  // Handshakes and effective request fields. When a handshake happens in the
  // cycle that also samples or commits, the live inputs are used, because the
  // latched copy only updates at the edge.
  // ---------------------------------------------------------------------------
  assign o_arready = (r_rd_state == R_IDLE) && w_ar_stall_done;
  assign o_rvalid  = (r_rd_state == R_RESP);
  assign o_awready = (r_wr_state == W_IDLE || r_wr_state == W_GOTW) && w_wr_stall_done;
  assign o_wready  = (r_wr_state == W_IDLE || r_wr_state == W_GOTA) && w_wr_stall_done;
  assign o_bvalid  = (r_wr_state == W_RESP);

  assign w_ar_hs = i_arvalid && o_arready;
  assign w_aw_hs = i_awvalid && o_awready;
  assign w_w_hs  = i_wvalid  && o_wready;

  assign w_rd_addr = w_ar_hs ? i_araddr : r_ar_addr;
  assign w_wr_addr = w_aw_hs ? i_awaddr : r_aw_addr;
  assign w_wr_data = w_w_hs  ? i_wdata  : r_wdata;
  assign w_wr_strb = w_w_hs  ? i_wstrb  : r_wstrb;

  assign w_rd_idx = w_rd_addr[AW_WORDS+1:2];
  assign w_wr_idx = w_wr_addr[AW_WORDS+1:2];
  assign w_rd_err = |w_rd_addr[31:AW_WORDS+2];
  assign w_wr_err = |w_wr_addr[31:AW_WORDS+2];

  // The byte lane bits do not select anything: a full word is always returned.
  assign w_unused = ^{w_rd_addr[1:0], w_wr_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_state_next = r_rd_state;
    w_rd_cnt_next   = r_rd_cnt;
    case (r_rd_state)
      R_IDLE: begin
        if (w_ar_hs) begin
          if (w_rd_total == 5'd0) begin
            w_rd_state_next = R_RESP;
          end else begin
            w_rd_state_next = R_WAIT;
            w_rd_cnt_next   = w_rd_total - 5'd1;
          end
        end
      end
      R_WAIT: begin
        if (r_rd_cnt == 5'd0) w_rd_state_next = R_RESP;
        else                  w_rd_cnt_next   = r_rd_cnt - 5'd1;
      end
      R_RESP: begin
        if (i_rready) w_rd_state_next = R_IDLE;
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  assign w_rd_sample = (w_rd_state_next == R_RESP) && (r_rd_state != R_RESP);

  // Write-first: when a write commits to the same word in the same cycle, the
  // read returns the merged data that the write is storing.
  assign w_rd_mem = r_mem[w_rd_idx];
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_merge
    assign w_rd_merged[8*gi +: 8] =
      (w_mem_we && (w_wr_idx == w_rd_idx) && w_wr_strb[gi]) ? w_wr_data[8*gi +: 8]
                                                            : w_rd_mem[8*gi +: 8];
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= 5'd0;
      r_ar_addr  <= 32'd0;
      r_rid      <= 4'd0;
      r_rdata    <= 32'd0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_state_next;
      r_rd_cnt   <= w_rd_cnt_next;
      if (w_ar_hs) begin
        r_ar_addr <= i_araddr;
        r_rid     <= i_arid;
      end
      if (w_rd_sample) begin
        r_rdata <= w_rd_err ? 32'd0 : w_rd_merged;
        r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign o_rid   = r_rid;
  assign o_rdata = r_rdata;
  assign o_rresp = r_rresp;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wr_go = 1'b0;
    case (r_wr_state)
      W_IDLE:  w_wr_go = w_aw_hs && w_w_hs;
      W_GOTA:  w_wr_go = w_w_hs;
      W_GOTW:  w_wr_go = w_aw_hs;
      default: w_wr_go = 1'b0;
    endcase
  end

  always_comb begin
    w_wr_state_next = r_wr_state;
    w_wr_cnt_next   = r_wr_cnt;
    case (r_wr_state)
      W_IDLE, W_GOTA, W_GOTW: begin
        if (w_wr_go) begin
          if (w_wr_total == 5'd0) begin
            w_wr_state_next = W_RESP;
          end else begin
            w_wr_state_next = W_WAIT;
            w_wr_cnt_next   = w_wr_total - 5'd1;
          end
        end else if (r_wr_state == W_IDLE && w_aw_hs) begin
          w_wr_state_next = W_GOTA;
        end else if (r_wr_state == W_IDLE && w_w_hs) begin
          w_wr_state_next = W_GOTW;
        end
      end
      W_WAIT: begin
        if (r_wr_cnt == 5'd0) w_wr_state_next = W_RESP;
        else                  w_wr_cnt_next   = r_wr_cnt - 5'd1;
      end
      W_RESP: begin
        if (i_bready) w_wr_state_next = W_IDLE;
      end
      default: w_wr_state_next = W_IDLE;
    endcase
  end

  assign w_wr_commit = (w_wr_state_next == W_RESP) && (r_wr_state != W_RESP);
  // The RAM has no reset, so a write is explicitly blocked while reset is held.
  assign w_mem_we    = w_wr_commit && !w_wr_err && i_aresetn;

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= 5'd0;
      r_aw_addr  <= 32'd0;
      r_bid      <= 4'd0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_next;
      r_wr_cnt   <= w_wr_cnt_next;
      if (w_aw_hs) begin
        r_aw_addr <= i_awaddr;
        r_bid     <= i_awid;
      end
      if (w_w_hs) begin
        r_wdata <= i_wdata;
        r_wstrb <= i_wstrb;
      end
      if (w_wr_commit) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  assign o_bid   = r_bid;
  assign o_bresp = r_bresp;

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//   Directed testbench for axi_sram_slave, built with RD_LAT=3 and WR_LAT=2 so
//   that the wait states are actually used. Inputs change on the falling edge
//   and outputs are inspected there.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;
  localparam int AWW = 10;
  localparam int RDL = 3;
  localparam int WRL = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        bready = 1'b0;
  logic        o_arready, o_rvalid, o_awready, o_wready, o_bvalid;
  logic [3:0]  o_rid, o_bid;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp, o_bresp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.AW_WORDS(AWW), .RD_LAT(RDL), .WR_LAT(WRL)) dut (
    .i_aclk(clk), .i_aresetn(rstn),
    .i_arid(arid), .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(rready),
    .i_awid(awid), .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(o_awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wvalid(wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(bready)
  );

  // n = falling edges since the request handshake at which the response was
  // first seen, or 0 if it never appeared.
  task automatic wait_r(output int n);
    n = 1;
    while (!o_rvalid && n < 40) begin @(negedge clk); n++; end
    if (!o_rvalid) n = 0;
  endtask

  task automatic wait_b(output int n);
    n = 1;
    while (!o_bvalid && n < 40) begin @(negedge clk); n++; end
    if (!o_bvalid) n = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] id, output logic [3:0] bid_o,
                          output logic [1:0] bresp_o, output int lat);
    awaddr = a; awid = id; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(lat);
    bid_o = o_bid; bresp_o = o_bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    $display("write addr=%08h data=%08h strb=%h id=%0d -> bid=%0d bresp=%0d lat=%0d",
             a, d, s, id, bid_o, bresp_o, lat);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, output logic [31:0] d_o,
                         output logic [3:0] rid_o, output logic [1:0] rresp_o, output int lat);
    araddr = a; arid = id; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    wait_r(lat);
    d_o = o_rdata; rid_o = o_rid; rresp_o = o_rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    $display("read  addr=%08h id=%0d -> rdata=%08h rid=%0d rresp=%0d lat=%0d",
             a, id, d_o, rid_o, rresp_o, lat);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_arready, o_awready, o_wready} !== 3'b111) begin
      errors++; $display("FAIL reset_ready: got %b expected 111", {o_arready, o_awready, o_wready});
    end
    checks++;
    if ({o_rvalid, o_bvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_valid: got %b expected 00", {o_rvalid, o_bvalid});
    end
    checks++;
    if ({o_rid, o_bid, o_rresp, o_bresp, o_rdata} !== 44'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {o_rid, o_bid, o_rresp, o_bresp, o_rdata});
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_arready, o_awready, o_wready, o_rvalid, o_bvalid} !== 5'b11100) begin
      errors++; $display("FAIL post_reset_idle: got %b expected 11100",
                         {o_arready, o_awready, o_wready, o_rvalid, o_bvalid});
    end
    $display("reset applied and released");
  endtask

  task automatic test_write_same_cycle();
    logic [3:0] bid; logic [1:0] bresp; int lat;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 4'd1, bid, bresp, lat);
    checks++;
    if (lat !== WRL) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, WRL); end
    checks++;
    if ({bid, bresp} !== {4'd1, 2'b00}) begin
      errors++; $display("FAIL wr_bid_bresp: got %h/%h expected 1/0", bid, bresp);
    end
    checks++;
    if ({o_bvalid, o_awready, o_wready} !== 3'b011) begin
      errors++; $display("FAIL wr_after_b: got %b expected 011", {o_bvalid, o_awready, o_wready});
    end
  endtask

  task automatic test_read_latency();
    logic [31:0] d; logic [3:0] rid; logic [1:0] rresp; int lat;
    do_read(32'h10, 4'd0, d, rid, rresp, lat);
    checks++;
    if (lat !== RDL) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, RDL); end
    checks++;
    if ({d, rid, rresp} !== {32'hDEADBEEF, 4'd0, 2'b00}) begin
      errors++; $display("FAIL rd_data: got %h/%h/%h expected deadbeef/0/0", d, rid, rresp);
    end
    checks++;
    if ({o_rvalid, o_arready} !== 2'b01) begin
      errors++; $display("FAIL rd_after_r: got %b expected 01", {o_rvalid, o_arready});
    end
    // Byte-lane bits of the address are ignored: the full word comes back.
    do_read(32'h13, 4'd5, d, rid, rresp, lat);
    checks++;
    if ({d, rid} !== {32'hDEADBEEF, 4'd5}) begin
      errors++; $display("FAIL rd_unaligned: got %h/%h expected deadbeef/5", d, rid);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [3:0] rid; logic [1:0] rresp; int lat;
    wdata = 32'h0000AB00; wstrb = 4'b0010; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    checks++;
    if ({o_awready, o_wready} !== 2'b10) begin
      errors++; $display("FAIL gotw_ready: got %b expected 10", {o_awready, o_wready});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (o_bvalid !== 1'b0) begin errors++; $display("FAIL gotw_early_b: got %b expected 0", o_bvalid); end
    awaddr = 32'h10; awid = 4'd2; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wait_b(lat);
    checks++;
    if ({lat[7:0], o_bid, o_bresp} !== {8'(WRL), 4'd2, 2'b00}) begin
      errors++; $display("FAIL gotw_resp: got lat=%0d bid=%0d bresp=%0d expected lat=%0d bid=2 bresp=0",
                         lat, o_bid, o_bresp, WRL);
    end
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    $display("write W-first addr=00000010 data=0000ab00 strb=2 id=2 -> lat=%0d", lat);
    do_read(32'h10, 4'd0, d, rid, rresp, lat);
    checks++;
    if (d !== 32'hDEADABEF) begin errors++; $display("FAIL strobe_merge: got %h expected deadabef", d); end
  endtask

  task automatic test_aw_before_w();
    logic [31:0] d; logic [3:0] rid; logic [1:0] rresp; int lat;
    awaddr = 32'h14; awid = 4'd3; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if ({o_awready, o_wready} !== 2'b01) begin
      errors++; $display("FAIL gota_ready: got %b expected 01", {o_awready, o_wready});
    end
    @(negedge clk);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    wait_b(lat);
    checks++;
    if ({lat[7:0], o_bid} !== {8'(WRL), 4'd3}) begin
      errors++; $display("FAIL gota_resp: got lat=%0d bid=%0d expected lat=%0d bid=3", lat, o_bid, WRL);
    end
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    $display("write AW-first addr=00000014 data=12345678 id=3 -> lat=%0d", lat);
    do_read(32'h14, 4'd0, d, rid, rresp, lat);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL gota_data: got %h expected 12345678", d); end
  endtask

  task automatic test_read_backpressure();
    int lat; int unstable;
    rready = 1'b0;
    araddr = 32'h14; arid = 4'd7; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    wait_r(lat);
    // A second request waits while the first response is held.
    araddr = 32'h10; arid = 4'd9; arvalid = 1'b1;
    unstable = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(o_rvalid === 1'b1 && o_rdata === 32'h12345678 && o_rid === 4'd7 && o_arready === 1'b0))
        unstable++;
    end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL rd_hold: got %0d unstable cycles expected 0", unstable); end
    rready = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_rvalid, o_arready} !== 2'b01) begin
      errors++; $display("FAIL rd_release: got %b expected 01", {o_rvalid, o_arready});
    end
    @(negedge clk);
    arvalid = 1'b0;
    wait_r(lat);
    checks++;
    if ({lat[7:0], o_rdata, o_rid} !== {8'(RDL), 32'hDEADABEF, 4'd9}) begin
      errors++; $display("FAIL rd_next: got lat=%0d data=%h rid=%0d expected lat=%0d data=deadabef rid=9",
                         lat, o_rdata, o_rid, RDL);
    end
    @(negedge clk);
    rready = 1'b0;
    $display("read held 5 cycles id=7, then id=9 -> rdata=deadabef");
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [3:0] id4; logic [1:0] resp; int lat;
    do_read(32'h8000_0010, 4'd4, d, id4, resp, lat);
    checks++;
    if ({resp, d, id4} !== {2'b10, 32'd0, 4'd4}) begin
      errors++; $display("FAIL rd_slverr: got %h/%h/%h expected 2/0/4", resp, d, id4);
    end
    do_write(32'h8000_0010, 32'hFFFFFFFF, 4'hF, 4'd6, id4, resp, lat);
    checks++;
    if ({resp, id4} !== {2'b10, 4'd6}) begin
      errors++; $display("FAIL wr_slverr: got %h/%h expected 2/6", resp, id4);
    end
    do_read(32'h10, 4'd0, d, id4, resp, lat);
    checks++;
    if (d !== 32'hDEADABEF) begin errors++; $display("FAIL wr_slverr_dropped: got %h expected deadabef", d); end
    // First address bit above the RAM must be rejected, not aliased onto word 0.
    do_write(32'h0, 32'h01020304, 4'hF, 4'd0, id4, resp, lat);
    do_write(32'h1000, 32'h55555555, 4'hF, 4'd0, id4, resp, lat);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL edge_slverr: got %h expected 2", resp); end
    do_read(32'h0, 4'd0, d, id4, resp, lat);
    checks++;
    if ({d, resp} !== {32'h01020304, 2'b00}) begin
      errors++; $display("FAIL edge_alias: got %h/%h expected 01020304/0", d, resp);
    end
    do_write(32'hFFC, 32'hCAFEF00D, 4'hF, 4'd0, id4, resp, lat);
    do_read(32'hFFC, 4'd0, d, id4, resp, lat);
    checks++;
    if ({d, resp} !== {32'hCAFEF00D, 2'b00}) begin
      errors++; $display("FAIL last_word: got %h/%h expected cafef00d/0", d, resp);
    end
  endtask

  task automatic test_write_first();
    logic [31:0] d; logic [3:0] id4; logic [1:0] resp; int lat;
    logic got_r; logic got_b; logic [31:0] rd;
    do_write(32'h20, 32'h11111111, 4'hF, 4'd0, id4, resp, lat);
    rready = 1'b1; bready = 1'b1;
    araddr = 32'h20; arid = 4'd1; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    // Timed so the write commits on the same edge the read samples.
    awaddr = 32'h20; awid = 4'd2; awvalid = 1'b1;
    wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    got_r = 1'b0; got_b = 1'b0; rd = '0;
    for (int n = 0; n < 20; n++) begin
      if (o_rvalid && !got_r) begin got_r = 1'b1; rd = o_rdata; end
      if (o_bvalid) got_b = 1'b1;
      if (got_r && got_b) break;
      @(negedge clk);
    end
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    $display("collision read/write addr=00000020 -> rdata=%08h", rd);
    checks++;
    if ({got_r, got_b, rd} !== {2'b11, 32'h11BB11DD}) begin
      errors++; $display("FAIL write_first: got r=%b b=%b data=%h expected 1/1/11bb11dd", got_r, got_b, rd);
    end
    do_read(32'h20, 4'd0, d, id4, resp, lat);
    checks++;
    if (d !== 32'h11BB11DD) begin errors++; $display("FAIL write_first_stored: got %h expected 11bb11dd", d); end
  endtask

  task automatic test_reset_mid();
    int stray; int lat; logic [31:0] d; logic [3:0] id4; logic [1:0] resp;
    rready = 1'b0;
    araddr = 32'h10; arid = 4'd3; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({o_rvalid, o_arready} !== 2'b01) begin
      errors++; $display("FAIL reset_in_wait: got %b expected 01", {o_rvalid, o_arready});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    stray = 0;
    repeat (10) begin @(negedge clk); if (o_rvalid !== 1'b0 || o_arready !== 1'b1) stray++; end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL reset_wait_stray: got %0d bad cycles expected 0", stray); end
    $display("reset during read wait -> no response");
    // Reset while a response is being held must drop rvalid at once.
    araddr = 32'h10; arid = 4'd3; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    wait_r(lat);
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({lat[7:0], o_rvalid, o_rdata} !== {8'(RDL), 1'b0, 32'd0}) begin
      errors++; $display("FAIL reset_in_resp: got lat=%0d rvalid=%b rdata=%h expected lat=%0d rvalid=0 rdata=0",
                         lat, o_rvalid, o_rdata, RDL);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    stray = 0;
    repeat (10) begin @(negedge clk); if (o_rvalid !== 1'b0) stray++; end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL reset_resp_stray: got %0d bad cycles expected 0", stray); end
    $display("reset during read response -> response dropped");
    do_read(32'h10, 4'd0, d, id4, resp, lat);
    checks++;
    if (d !== 32'hDEADABEF) begin errors++; $display("FAIL ram_kept: got %h expected deadabef", d); end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_read_latency();
    test_w_before_aw();
    test_aw_before_w();
    test_read_backpressure();
    test_slverr();
    test_write_first();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
